// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO: a one-bit-per-cycle shift-add
// multiplier and a restoring divider share a single double-width working register.
module mips_cpu_muldiv_ctrl #(
    parameter int WIDTH         = 32,
    parameter bit ZERO_DIV_KEEP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return neg_word(v, is_signed & v[WIDTH-1]);
    endfunction

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 sign_q, sign_d;
    logic                 rsign_q, rsign_d;
    logic                 dz_q, dz_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 op_signed;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        op_signed = ~op[0];
        // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        prod      = neg_prod(acc_q, sign_q);
        quo       = neg_word(acc_q[WIDTH-1:0], sign_q);
        rem       = neg_word(acc_q[2*WIDTH-1:WIDTH], rsign_q);

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        case (op)
                            3'b000, 3'b001: begin
                                mcand_d  = magnitude(b, op_signed);
                                acc_d    = {{WIDTH{1'b0}}, magnitude(a, op_signed)};
                                sign_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                rsign_d  = 1'b0;
                                dz_d     = 1'b0;
                                is_div_d = 1'b0;
                                count_d  = '0;
                                state_d  = MUL;
                                busy_d   = 1'b1;
                            end
                            3'b010, 3'b011: begin
                                is_div_d = 1'b1;
                                count_d  = '0;
                                busy_d   = 1'b1;
                                if (b == '0) begin
                                    // dividend is parked in the low half for the non-keep policy
                                    dz_d    = 1'b1;
                                    acc_d   = {{WIDTH{1'b0}}, a};
                                    sign_d  = 1'b0;
                                    rsign_d = 1'b0;
                                    state_d = FIX;
                                end else begin
                                    dz_d    = 1'b0;
                                    mcand_d = magnitude(b, op_signed);
                                    acc_d   = {{WIDTH{1'b0}}, magnitude(a, op_signed)};
                                    sign_d  = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    rsign_d = op_signed & a[WIDTH-1];
                                    state_d = DIV;
                                end
                            end
                            3'b100: begin
                                hi_d   = a;
                                done_d = 1'b1;
                            end
                            3'b101: begin
                                lo_d   = a;
                                done_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_d = FIX;
                end
                DIV: begin
                    if (div_trial[WIDTH])
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_d = FIX;
                end
                FIX: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (dz_q) begin
                        if (!ZERO_DIV_KEEP) begin
                            hi_d = acc_q[WIDTH-1:0];
                            lo_d = '1;
                        end
                    end else if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Bench for mips_cpu_muldiv_ctrl: two instances (keep / overwrite on divide-by-zero)
// compared every cycle against a countdown-based arithmetic model, plus literal checks.
module tb_mips_cpu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0, hi1, lo1;

    always #5 clk = ~clk;

    mips_cpu_muldiv_ctrl #(.WIDTH(32), .ZERO_DIV_KEEP(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

    mips_cpu_muldiv_ctrl #(.WIDTH(32), .ZERO_DIV_KEEP(1'b0)) dut_nk (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

    int checks = 0;
    int errors = 0;

    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    logic [31:0] p_hi[2];
    logic [31:0] p_lo[2];
    bit          p_wr[2];

    task automatic model_step();
        logic signed [63:0] sa, sb, q64, r64;
        logic [63:0]        p;
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_hi[k] = 32'd0;
                m_lo[k] = 32'd0;
            end
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0;
                m_done = 1'b0;
            end else begin
                m_left--;
                m_done = (m_left == 0);
                if (m_left == 0)
                    for (int k = 0; k < 2; k++)
                        if (p_wr[k]) begin
                            m_hi[k] = p_hi[k];
                            m_lo[k] = p_lo[k];
                        end
            end
        end else begin
            m_done = 1'b0;
            if (start && !abort) begin
                sa = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
                sb = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
                case (op)
                    3'd4: begin
                        for (int k = 0; k < 2; k++) m_hi[k] = a;
                        m_done = 1'b1;
                    end
                    3'd5: begin
                        for (int k = 0; k < 2; k++) m_lo[k] = a;
                        m_done = 1'b1;
                    end
                    3'd0, 3'd1: begin
                        p = sa * sb;
                        for (int k = 0; k < 2; k++) begin
                            p_hi[k] = p[63:32];
                            p_lo[k] = p[31:0];
                            p_wr[k] = 1'b1;
                        end
                        m_left = 33;
                    end
                    3'd2, 3'd3: begin
                        if (b == 32'd0) begin
                            p_wr[0] = 1'b0;
                            p_wr[1] = 1'b1;
                            p_hi[1] = a;
                            p_lo[1] = 32'hFFFFFFFF;
                            m_left  = 1;
                        end else begin
                            q64 = sa / sb;
                            r64 = sa % sb;
                            for (int k = 0; k < 2; k++) begin
                                p_hi[k] = r64[31:0];
                                p_lo[k] = q64[31:0];
                                p_wr[k] = 1'b1;
                            end
                            m_left = 33;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_dut(input int k, input logic bz, input logic dn,
                             input logic [31:0] h, input logic [31:0] l);
        logic eb;
        eb = (m_left > 0);
        checks++;
        if (bz !== eb || dn !== m_done || h !== m_hi[k] || l !== m_lo[k]) begin
            errors++;
            $display("FAIL cycle_cmp dut%0d t=%0t got busy=%b done=%b hi=%h lo=%h required busy=%b done=%b hi=%h lo=%h",
                     k, $time, bz, dn, h, l, eb, m_done, m_hi[k], m_lo[k]);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_dut(0, busy0, done0, hi0, lo0);
        check_dut(1, busy1, done1, hi1, lo1);
    endtask

    // Issue one op, then pester the busy unit with random starts until it finishes.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output int busy_cycles);
        int n;
        start = 1'b1; op = o; a = av; b = bv; abort = 1'b0;
        cyc();
        busy_cycles = int'(busy0);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 0;
        while ((m_left > 0 || busy0) && n < 40) begin
            start = (m_left > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            op = 3'($urandom_range(0, 7));
            cyc();
            busy_cycles += int'(busy0);
            n++;
        end
        start = 1'b0;
        if (n >= 40) begin
            errors++;
            $display("FAIL timeout t=%0t got busy=%b required busy=0 within 40 cycles", $time, busy0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        for (int k = 0; k < 2; k++) begin
            m_hi[k] = 32'd0; m_lo[k] = 32'd0;
            p_hi[k] = 32'd0; p_lo[k] = 32'd0; p_wr[k] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) cyc();
        check_lit("rst_busy", {31'd0, busy0}, 32'd0);
        check_lit("rst_hi", hi0, 32'd0);
        check_lit("rst_lo", lo0, 32'd0);
        reset = 1'b1;
        cyc();

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
        check_lit("multu_busy_len", bc, 33);
        check_lit("multu_hi", hi0, 32'hFFFFFFFE);
        check_lit("multu_lo", lo0, 32'h00000001);
        check_lit("multu_model_hi", m_hi[0], 32'hFFFFFFFE);

        issue(3'd0, 32'hFFFFFFFD, 32'h00000007, bc);
        check_lit("mult_neg_hi", hi0, 32'hFFFFFFFF);
        check_lit("mult_neg_lo", lo0, 32'hFFFFFFEB);
        issue(3'd0, 32'h80000000, 32'h80000000, bc);
        check_lit("mult_min_hi", hi0, 32'h40000000);
        check_lit("mult_min_lo", lo0, 32'h00000000);

        issue(3'd2, 32'hFFFFFFF9, 32'h00000002, bc);
        check_lit("div_neg_lo", lo0, 32'hFFFFFFFD);
        check_lit("div_neg_hi", hi0, 32'hFFFFFFFF);
        check_lit("div_model_lo", m_lo[0], 32'hFFFFFFFD);
        issue(3'd3, 32'd100, 32'd7, bc);
        check_lit("divu_lo", lo0, 32'h0000000E);
        check_lit("divu_hi", hi0, 32'h00000002);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, bc);
        check_lit("div_ovf_lo", lo0, 32'h80000000);
        check_lit("div_ovf_hi", hi0, 32'h00000000);

        issue(3'd4, 32'h11, 32'd0, bc);
        issue(3'd5, 32'h22, 32'd0, bc);
        issue(3'd3, 32'd5, 32'd0, bc);
        check_lit("dz_busy_len", bc, 1);
        check_lit("dz_keep_hi", hi0, 32'h11);
        check_lit("dz_keep_lo", lo0, 32'h22);
        check_lit("dz_over_hi", hi1, 32'h5);
        check_lit("dz_over_lo", lo1, 32'hFFFFFFFF);

        start = 1'b1; op = 3'd4; a = 32'hAAAA0000;
        cyc();
        check_lit("mthi_done", {31'd0, done0}, 32'd1);
        op = 3'd5; a = 32'h0000BBBB;
        cyc();
        check_lit("mtlo_done", {31'd0, done0}, 32'd1);
        check_lit("mt_busy", {31'd0, busy0}, 32'd0);
        start = 1'b0;
        cyc();
        check_lit("mt_hi", hi0, 32'hAAAA0000);
        check_lit("mt_lo", lo0, 32'h0000BBBB);

        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_lit("abort_busy", {31'd0, busy0}, 32'd0);
        check_lit("abort_done", {31'd0, done0}, 32'd0);
        repeat (35) cyc();
        check_lit("abort_hi", hi0, 32'hAAAA0000);
        check_lit("abort_lo", lo0, 32'h0000BBBB);

        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check_lit("mrst_hi", hi0, 32'd0);
        check_lit("mrst_lo", lo0, 32'd0);
        check_lit("mrst_busy", {31'd0, busy0}, 32'd0);
        check_lit("mrst_done", {31'd0, done0}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) != 0);
            abort = ($urandom_range(0, 119) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            a     = pick();
            b     = pick();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
